piso_serializer: RTL and testbench

Parallel-in serial-out transmitter. It is the unloading end of the team's parallel load register.
- Accepts an N-bit word through a valid/ready load handshake.
- Shifts the word out MSB-first, one bit per accepted beat, with downstream backpressure.
- Pulses done after the last bit. Sits between a register/datapath word source and a serial link or a downstream deserializer.

---
 rtl/piso_pkg.sv | 16 +
 rtl/bit_down_counter.sv | 27 ++
 rtl/piso_serializer.sv | 97 +++++++++
 tb/tb_piso_serializer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/piso_pkg.sv
// rtl/piso_pkg.sv - shared state encoding and width helper for the PISO serializer
package piso_pkg;

   // 2'd3 is unused and falls back to IDLE in the next-state logic
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   // Bit-counter width: enough bits to hold N-1, never narrower than one bit
   function automatic int cw_of(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/bit_down_counter.sv
// rtl/bit_down_counter.sv - loadable down-counter with enable and zero flag
module bit_down_counter #(
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_value,
   input  logic         en,
   output logic [W-1:0] count,
   output logic         zero
);

   // Load has priority; decrement saturates at zero so the count never wraps
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= '0;
      end else if (load) begin
         count <= load_value;
      end else if (en && (count != '0)) begin
         count <= count - W'(1);
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - parallel-in serial-out transmitter, MSB first, with backpressure
module piso_serializer
   import piso_pkg::*;
#(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load_valid,
   output logic         load_ready,
   input  logic [N-1:0] data_in,
   output logic         ser_valid,
   input  logic         ser_ready,
   output logic         ser_out,
   output logic         ser_last,
   output logic         done
);

   localparam int CW = cw_of(N);

   state_t        state;
   state_t        state_next;
   logic [N-1:0]  shreg;
   logic [CW-1:0] count;
   logic          zero;
   logic          accept;
   logic          advance;

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state decode plus the load/advance strobes for the datapath
   always_comb begin
      state_next = state;
      accept     = 1'b0;
      advance    = 1'b0;
      case (state)
         IDLE: begin
            if (load_valid) begin
               accept     = 1'b1;
               state_next = SHIFT;
            end
         end
         SHIFT: begin
            if (ser_ready) begin
               advance = 1'b1;
               if (zero) begin
                  state_next = DONE;
               end
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Shift register: capture on acceptance, shift left on each accepted non-final bit
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         shreg <= '0;
      end else if (accept) begin
         shreg <= data_in;
      end else if (advance && !zero) begin
         shreg <= shreg << 1;
      end
   end

   bit_down_counter #(
      .W (CW)
   ) u_count (
      .clk        (clk),
      .rst        (rst),
      .load       (accept),
      .load_value (CW'(N - 1)),
      .en         (advance),
      .count      (count),
      .zero       (zero)
   );

   // Outputs depend only on registered state, shift register and count
   assign load_ready = (state == IDLE);
   assign ser_valid  = (state == SHIFT);
   assign ser_out    = ser_valid & shreg[N-1];
   assign ser_last   = ser_valid & zero;
   assign done       = (state == DONE);

endmodule

// File: tb/tb_piso_serializer.sv
// tb/tb_piso_serializer.sv - scoreboard bench for the PISO serializer
module tb_piso_serializer;

   localparam int N = 8;

   typedef struct {
      logic b;
      logic last;
   } exp_t;

   logic         clk;
   logic         rst;
   logic         load_valid;
   logic         load_ready;
   logic [N-1:0] data_in;
   logic         ser_valid;
   logic         ser_ready;
   logic         ser_out;
   logic         ser_last;
   logic         done;

   exp_t sb[$];
   int   n_cmp;
   int   n_bad;
   int   cyc;
   logic pend_done;

   piso_serializer #(.N(N)) dut (
      .clk        (clk),
      .rst        (rst),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .data_in    (data_in),
      .ser_valid  (ser_valid),
      .ser_ready  (ser_ready),
      .ser_out    (ser_out),
      .ser_last   (ser_last),
      .done       (done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Monitor: push expected bits on acceptance, pop and compare on accepted serial beats
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         sb.delete();
         pend_done = 1'b0;
      end else begin
         check_eq("done", done, pend_done);
         pend_done = 1'b0;
         if (ser_valid) begin
            if (ser_ready) begin
               check_eq("bit_expected", sb.size() != 0, 1);
               if (sb.size() != 0) begin
                  e = sb.pop_front();
                  check_eq("ser_out", ser_out, e.b);
                  check_eq("ser_last", ser_last, e.last);
                  pend_done = e.last;
               end
            end
         end else begin
            check_eq("idle_out_last", {ser_out, ser_last}, 0);
         end
         if (load_valid && load_ready) begin
            for (int i = 0; i < N; i++) begin
               e.b    = data_in[N-1-i];
               e.last = (i == N - 1);
               sb.push_back(e);
            end
         end
      end
   end

   // Present a word and return one cycle after it is accepted; acc = cycle of acceptance
   task automatic load_word(input logic [N-1:0] d, output int acc);
      bit ok;
      ok  = 1'b0;
      acc = 0;
      load_valid = 1'b1;
      data_in    = d;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (load_ready) begin
            ok  = 1'b1;
            acc = cyc;
            break;
         end
      end
      check_eq("load_accepted", ok, 1);
      @(posedge clk);
      #1;
      load_valid = 1'b0;
   endtask

   // Wait for the done pulse; dc = cycle in which done was seen
   task automatic wait_done(output int dc);
      bit ok;
      ok = 1'b0;
      dc = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done) begin
            ok = 1'b1;
            dc = cyc;
            break;
         end
      end
      check_eq("done_seen", ok, 1);
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      int  acc;
      int  acc2;
      int  dc;
      bit  ok;
      n_cmp      = 0;
      n_bad      = 0;
      cyc        = 0;
      pend_done  = 1'b0;
      rst        = 1'b0;
      load_valid = 1'b0;
      data_in    = '0;
      ser_ready  = 1'b1;

      // 1. reset state before any clock edge
      #2;
      check_eq("rst_load_ready", load_ready, 1);
      check_eq("rst_ser_valid", ser_valid, 0);
      check_eq("rst_ser_out", ser_out, 0);
      check_eq("rst_ser_last", ser_last, 0);
      check_eq("rst_done", done, 0);
      step(2);
      rst = 1'b1;
      step(1);

      // 2. basic word
      load_word(8'h55, acc);
      wait_done(dc);
      check_eq("basic_latency", dc - acc, N + 1);
      check_eq("done_load_ready", load_ready, 0);
      check_eq("done_ser_valid", ser_valid, 0);
      @(negedge clk);
      check_eq("idle_after_done", load_ready, 1);
      step(1);

      // 3+4. backpressure on the third bit, with an ignored load attempt during SHIFT
      load_word(8'hAA, acc);
      load_valid = 1'b1;
      data_in    = 8'hFF;
      step(2);
      ser_ready = 1'b0;
      @(negedge clk);
      check_eq("stall_bit", ser_out, 1);
      check_eq("shift_load_ready", load_ready, 0);
      step(1);
      @(negedge clk);
      check_eq("stall_bit_held", ser_out, 1);
      check_eq("stall_valid_held", ser_valid, 1);
      step(1);
      ser_ready  = 1'b1;
      load_valid = 1'b0;
      wait_done(dc);
      check_eq("stall_latency", dc - acc, N + 3);
      step(2);

      // 5. reset mid-word
      load_word(8'hFF, acc);
      step(3);
      #3;
      rst = 1'b0;
      #1;
      check_eq("midrst_ser_valid", ser_valid, 0);
      check_eq("midrst_load_ready", load_ready, 1);
      check_eq("midrst_ser_out", ser_out, 0);
      check_eq("midrst_done", done, 0);
      step(2);
      rst = 1'b1;
      step(12);
      load_word(8'h0F, acc);
      wait_done(dc);
      check_eq("post_rst_latency", dc - acc, N + 1);
      step(1);

      // 6. back-to-back loads with load_valid held high
      load_valid = 1'b1;
      data_in    = 8'h55;
      ok = 1'b0;
      acc = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (load_ready) begin
            ok = 1'b1;
            acc = cyc;
            break;
         end
      end
      check_eq("b2b_first_accept", ok, 1);
      @(posedge clk);
      #1;
      data_in = 8'hAA;
      ok = 1'b0;
      acc2 = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (load_ready) begin
            ok = 1'b1;
            acc2 = cyc;
            break;
         end
      end
      check_eq("b2b_second_accept", ok, 1);
      check_eq("b2b_spacing", acc2 - acc, N + 2);
      @(posedge clk);
      #1;
      load_valid = 1'b0;
      wait_done(dc);
      check_eq("b2b_latency", dc - acc2, N + 1);
      step(3);

      check_eq("scoreboard_empty", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
